// File: rtl/mult_arbiter_pkg.sv
// Shared definitions for the mult1 arbiter: FSM state encoding, default latency
// and the round-robin pointer advance helper.
package mult_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_RESP  = 3'd4
  } state_e;

  localparam int DEFAULT_MULT_LAT = 33;

  function automatic int rr_next(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/mult_rr_pick.sv
// Combinational round-robin pick: first set request at or after rr_ptr, wrapping.
// Kept standalone so other shared units can reuse it.
module mult_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] rr_ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IDXW-1:0] gnt_idx,
  output logic            any
);

  // scan NREQ positions starting at rr_ptr; the first hit wins
  always_comb begin
    logic [IDXW:0]   sum;
    logic [IDXW-1:0] idx;
    logic            hit;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    sum     = '0;
    idx     = '0;
    hit     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum = {1'b0, rr_ptr} + (IDXW+1)'(i);
      if (sum >= (IDXW+1)'(NREQ)) begin
        sum = sum - (IDXW+1)'(NREQ);
      end else begin
        sum = sum;
      end
      idx          = sum[IDXW-1:0];
      hit          = !any && req[idx];
      gnt_oh[idx]  = gnt_oh[idx] | hit;
      gnt_idx      = hit ? idx : gnt_idx;
      any          = any | hit;
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one iterative mult1 between NREQ requesters.
// Optional op counter port enabled by defining MULT_ARB_STATS_EN.
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = DEFAULT_MULT_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_in,
  input  logic [NREQ*WIDTH-1:0] b_in,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_product,
  output logic                  m_start,
  output logic                  m_ack,
  output logic [WIDTH-1:0]      m_multiplicand,
  output logic [WIDTH-1:0]      m_multiplier,
  input  logic [2*WIDTH-1:0]    m_product
`ifdef MULT_ARB_STATS_EN
  ,
  output logic [31:0]           op_count
`endif
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(MULT_LAT + 1);

  state_e              state_q, state_d;
  logic [IDXW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDXW-1:0]     owner_q, owner_d;
  logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
  logic [2*WIDTH-1:0]  result_q, result_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;

  logic [NREQ-1:0]     pick_oh;
  logic [IDXW-1:0]     pick_idx;
  logic                pick_any;
  logic [WIDTH-1:0]    a_sel, b_sel;
  logic [NREQ-1:0]     owner_oh;
  logic                ready_hit;

  mult_rr_pick #(.NREQ(NREQ), .IDXW(IDXW)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // operand mux for the picked requester and owner decode
  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      a_sel       = a_sel | ({WIDTH{pick_oh[i]}} & a_in[i*WIDTH +: WIDTH]);
      b_sel       = b_sel | ({WIDTH{pick_oh[i]}} & b_in[i*WIDTH +: WIDTH]);
      owner_oh[i] = (owner_q == IDXW'(i));
    end
    ready_hit = |(rsp_ready & owner_oh);
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // next state; WAIT runs cnt from MULT_LAT-1 down to 0, i.e. exactly MULT_LAT cycles
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d = S_START;
          owner_d = pick_idx;
          a_d     = a_sel;
          b_d     = b_sel;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = CNTW'(MULT_LAT - 1);
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          result_d = m_product;
          state_d  = S_ACK;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end
      S_ACK: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (ready_hit) begin
          rr_ptr_d = IDXW'(rr_next(int'(owner_q), NREQ));
          state_d  = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // protocol outputs; gnt is masked while reset is asserted since no latch happens then
  always_comb begin
    if (state_q == S_IDLE && rst) begin
      gnt = pick_oh;
    end else begin
      gnt = '0;
    end
    m_start   = (state_q == S_START);
    m_ack     = (state_q == S_ACK);
    rsp_valid = (state_q == S_RESP) ? owner_oh : '0;
  end

  assign rsp_product    = result_q;
  assign m_multiplicand = a_q;
  assign m_multiplier   = b_q;

`ifdef MULT_ARB_STATS_EN
  logic [31:0] op_count_q, op_count_d;

  // completed operations, wrapping naturally at 2^32
  always_comb begin
    if (state_q == S_RESP && ready_hit) begin
      op_count_d = op_count_q + 32'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // op counter register
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_count_q <= 32'd0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: directed op table, hand-written corner sequences and a
// randomized phase checked cycle-by-cycle against a transaction-level reference.
module tb_mult_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 33;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req, gnt, rsp_valid, rsp_ready;
  logic [N*W-1:0]   a_in, b_in;
  logic [2*W-1:0]   rsp_product, m_product;
  logic             m_start, m_ack;
  logic [W-1:0]     m_multiplicand, m_multiplier;
`ifdef MULT_ARB_STATS_EN
  logic [31:0]      op_count;
`endif

  always #5 clk = ~clk;

  mult_arbiter #(.NREQ(N), .WIDTH(W), .MULT_LAT(L)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_product(rsp_product),
    .m_start(m_start), .m_ack(m_ack), .m_multiplicand(m_multiplicand),
    .m_multiplier(m_multiplier), .m_product(m_product)
`ifdef MULT_ARB_STATS_EN
    , .op_count(op_count)
`endif
  );

  // behavioural mult1: product only visible once the latency has elapsed
  int          mc;
  logic        mbusy;
  logic [63:0] mprod;
  always @(posedge clk) begin
    if (!rst) begin
      mbusy <= 1'b0; mc <= 0; mprod <= 64'd0;
    end else if (m_start) begin
      mbusy <= 1'b1; mc <= L - 1;
      mprod <= {32'd0, m_multiplicand} * {32'd0, m_multiplier};
    end else if (m_ack) begin
      mbusy <= 1'b0;
    end else if (mbusy && mc > 0) begin
      mc <= mc - 1;
    end
  end
  assign m_product = (mbusy && mc == 0) ? mprod : 64'hBAD0_0BAD_DEAD_BEEF;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // transaction-level reference state
  bit          ref_busy;
  int          ref_owner, ref_t0, ref_ptr;
  logic [31:0] ref_a, ref_b, ref_cnt;
  logic [63:0] ref_res, ref_exp;

  // outputs observed in the most recent step
  logic [N-1:0] o_gnt, o_valid;
  logic         o_start, o_ack;
  logic [63:0]  o_prod;
  logic [31:0]  o_a, o_b, o_cnt;

  typedef struct {
    int          who;
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    logic [63:0] exp_prod;
  } vec_t;

  vec_t tbl[5];
  int   exp_own[5] = '{0, 1, 2, 3, 0};
  logic [63:0] exp_rr_prod[5] = '{64'd7, 64'd14, 64'd21, 64'd28, 64'd7};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // apply one cycle of inputs, check against the reference, then clock
  task automatic step(input logic r_rst, input logic [N-1:0] r_req, input logic [N*W-1:0] r_a,
                      input logic [N*W-1:0] r_b, input logic [N-1:0] r_rdy);
    int k;
    int pick;
    logic [N-1:0] e_gnt, e_valid;
    rst = r_rst; req = r_req; a_in = r_a; b_in = r_b; rsp_ready = r_rdy;
    #1;
    k = cyc - ref_t0;
    pick = -1;
    e_gnt = '0;
    e_valid = '0;
    if (!ref_busy && r_rst)
      for (int i = 0; i < N; i++)
        if (pick < 0 && r_req[(ref_ptr + i) % N]) pick = (ref_ptr + i) % N;
    if (pick >= 0) e_gnt[pick] = 1'b1;
    if (ref_busy && k >= L + 3) e_valid[ref_owner] = 1'b1;
    chk("gnt", gnt, e_gnt);
    chk("m_start", m_start, ref_busy && k == 1);
    chk("m_ack", m_ack, ref_busy && k == L + 2);
    chk("rsp_valid", rsp_valid, e_valid);
    chk("rsp_product", rsp_product, ref_res);
    chk("m_multiplicand", m_multiplicand, ref_a);
    chk("m_multiplier", m_multiplier, ref_b);
`ifdef MULT_ARB_STATS_EN
    chk("op_count", op_count, ref_cnt);
    o_cnt = op_count;
`endif
    o_gnt = gnt; o_valid = rsp_valid; o_start = m_start; o_ack = m_ack;
    o_prod = rsp_product; o_a = m_multiplicand; o_b = m_multiplier;
    if (!r_rst) begin
      ref_busy = 1'b0; ref_ptr = 0; ref_a = '0; ref_b = '0; ref_res = '0; ref_cnt = '0;
    end else if (pick >= 0) begin
      ref_busy = 1'b1; ref_owner = pick; ref_t0 = cyc;
      ref_a = r_a[pick*W +: W]; ref_b = r_b[pick*W +: W];
      ref_exp = {32'd0, ref_a} * {32'd0, ref_b};
    end else if (ref_busy) begin
      if (k == L + 1) ref_res = ref_exp;
      if (k >= L + 3 && r_rdy[ref_owner]) begin
        ref_busy = 1'b0; ref_ptr = (ref_owner + 1) % N; ref_cnt = ref_cnt + 32'd1;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // one complete op from an idle arbiter, checked against the fixed timeline
  task automatic run_op(input vec_t v);
    logic [N*W-1:0] pa, pb;
    logic [N-1:0]   oh, rq, rd;
    oh = 4'b0001 << v.who;
    for (int c = 0; c <= L + 3 + v.stall; c++) begin
      pa = {$urandom, $urandom, $urandom, $urandom};
      pb = {$urandom, $urandom, $urandom, $urandom};
      pa[v.who*W +: W] = v.a;
      pb[v.who*W +: W] = v.b;
      rq = (c == 0) ? oh : ((v.stall > 0) ? ~oh : 4'b0000);
      rd = (c >= L + 3 + v.stall) ? 4'b1111 : ~oh;
      step(1'b1, rq, pa, pb, rd);
      chk("op_gnt", o_gnt, (c == 0) ? oh : 4'b0000);
      chk("op_start", o_start, c == 1);
      chk("op_ack", o_ack, c == L + 2);
      chk("op_valid", o_valid, (c >= L + 3) ? oh : 4'b0000);
      if (c >= L + 3) chk("op_product", o_prod, v.exp_prod);
    end
  endtask

  initial begin
    int g_own[$];
    int g_cyc[$];
    logic [63:0] prods[$];
    logic [N*W-1:0] pa, pb;
    logic [N-1:0] rq;

    tbl[0] = '{0, 32'd10, 32'd3, 0, 64'd30};
    tbl[1] = '{2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 10, 64'hFFFF_FFFE_0000_0001};
    tbl[2] = '{1, 32'd6, 32'd7, 0, 64'd42};
    tbl[3] = '{3, 32'd0, 32'd12345, 2, 64'd0};
    tbl[4] = '{1, 32'h8000_0000, 32'd2, 3, 64'h1_0000_0000};

    rst = 1'b0; req = '0; a_in = '0; b_in = '0; rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    ref_busy = 1'b0; ref_owner = 0; ref_t0 = 0; ref_ptr = 0;
    ref_a = '0; ref_b = '0; ref_res = '0; ref_exp = '0; ref_cnt = '0;

    // reset state
    step(1'b1, 4'b0000, '0, '0, 4'b0000);
    chk("reset_prod", o_prod, 64'd0);
    chk("reset_a", o_a, 32'd0);

    for (int t = 0; t < 5; t++) run_op(tbl[t]);

    // contention with all requests held
    step(1'b0, 4'b0000, '0, '0, 4'b0000);
    for (int i = 0; i < N; i++) begin
      pa[i*W +: W] = 32'(i + 1);
      pb[i*W +: W] = 32'd7;
    end
    for (int c = 0; c < 5 * (L + 4); c++) begin
      step(1'b1, 4'b1111, pa, pb, 4'b1111);
      for (int i = 0; i < N; i++)
        if (o_gnt[i]) begin g_own.push_back(i); g_cyc.push_back(c); end
      if (o_valid != 4'b0000) prods.push_back(o_prod);
    end
    chk("rr_grants", 64'(g_own.size()), 64'd5);
    chk("rr_products", 64'(prods.size()), 64'd5);
    for (int i = 0; i < 5; i++) begin
      chk("rr_owner", (i < g_own.size()) ? 64'(g_own[i]) : 64'hFFFF, 64'(exp_own[i]));
      chk("rr_prod", (i < prods.size()) ? prods[i] : 64'hFFFF, exp_rr_prod[i]);
      if (i > 0 && i < g_cyc.size()) chk("rr_period", 64'(g_cyc[i] - g_cyc[i-1]), 64'(L + 4));
    end

    // reset in the middle of WAIT aborts silently
    pa = '0; pb = '0;
    pa[2*W +: W] = 32'd3; pb[2*W +: W] = 32'd4;
    for (int c = 0; c < 15; c++) step(1'b1, (c == 0) ? 4'b0100 : 4'b0000, pa, pb, 4'b1111);
    step(1'b0, 4'b0000, pa, pb, 4'b1111);
    step(1'b1, 4'b0000, pa, pb, 4'b1111);
    chk("abort_start", o_start, 1'b0);
    chk("abort_ack", o_ack, 1'b0);
    chk("abort_valid", o_valid, 4'b0000);
    chk("abort_prod", o_prod, 64'd0);
    chk("abort_a", o_a, 32'd0);
    chk("abort_b", o_b, 32'd0);
    run_op(tbl[2]);

    // operand change after grant, late request served only after RESP
    for (int c = 0; c <= 2 * (L + 4); c++) begin
      pa = '0; pb = '0;
      pa[3*W +: W] = (c == 0) ? 32'd5 : 32'd9;
      pb[3*W +: W] = 32'd5;
      pa[1*W +: W] = 32'd2;
      pb[1*W +: W] = 32'd8;
      rq = (c == 0) ? 4'b1000 : ((c >= 5 && c <= L + 4) ? 4'b0010 : 4'b0000);
      step(1'b1, rq, pa, pb, 4'b1111);
      chk("late_gnt", o_gnt, (c == 0) ? 4'b1000 : ((c == L + 4) ? 4'b0010 : 4'b0000));
      if (c == L + 3) begin
        chk("latched_valid", o_valid, 4'b1000);
        chk("latched_prod", o_prod, 64'd25);
      end
      if (c == 2 * L + 7) chk("late_prod", o_prod, 64'd16);
    end

`ifdef MULT_ARB_STATS_EN
    step(1'b0, 4'b0000, '0, '0, 4'b0000);
    for (int t = 0; t < 5; t++) run_op(tbl[0]);
    step(1'b1, 4'b0000, '0, '0, 4'b0000);
    chk("stats_five", o_cnt, 32'd5);
    step(1'b0, 4'b0000, '0, '0, 4'b0000);
    step(1'b1, 4'b0000, '0, '0, 4'b0000);
    chk("stats_reset", o_cnt, 32'd0);
`endif

    // randomized traffic with occasional reset
    rq = 4'b0000;
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        pa[i*W +: W] = rnd_op();
        pb[i*W +: W] = rnd_op();
      end
      step(($urandom_range(0, 299) != 0), rq, pa, pb, 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
